// File: rtl/step_dir_mc.sv
// Multi-channel step/dir to WIDTH-phase coil sequencer: wave/full/half modes, enable, signed position, sticky fault.
// Define STEP_DIR_SYNC_EN to pass step/dir/ena through 2-FF synchronizers (adds 2 clk latency).
module step_dir_mc #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 5,
    parameter int POS_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          aclr,
    input  logic                          i_sclr,
    input  logic [CHANNELS-1:0]           i_step,
    input  logic [CHANNELS-1:0]           i_dir,
    input  logic [2*CHANNELS-1:0]         i_mode,
    input  logic [CHANNELS-1:0]           i_ena,
    output logic [CHANNELS*WIDTH-1:0]     o_phase,
    output logic [CHANNELS-1:0]           o_changed,
    output logic [CHANNELS*POS_WIDTH-1:0] o_pos,
    output logic [CHANNELS-1:0]           o_fault
);
    localparam int          CW    = $clog2(2*WIDTH);
    localparam logic [CW:0] TWO_W = (CW+1)'(2*WIDTH);

    logic [CHANNELS-1:0] w_step;
    logic [CHANNELS-1:0] w_dir;
    logic [CHANNELS-1:0] w_ena;

`ifdef STEP_DIR_SYNC_EN
    logic [CHANNELS-1:0] r_step_s1, r_step_s2;
    logic [CHANNELS-1:0] r_dir_s1,  r_dir_s2;
    logic [CHANNELS-1:0] r_ena_s1,  r_ena_s2;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_step_s1 <= '0;
            r_step_s2 <= '0;
            r_dir_s1  <= '0;
            r_dir_s2  <= '0;
            r_ena_s1  <= '0;
            r_ena_s2  <= '0;
        end else begin
            r_step_s1 <= i_step;
            r_step_s2 <= r_step_s1;
            r_dir_s1  <= i_dir;
            r_dir_s2  <= r_dir_s1;
            r_ena_s1  <= i_ena;
            r_ena_s2  <= r_ena_s1;
        end
    end

    assign w_step = r_step_s2;
    assign w_dir  = r_dir_s2;
    assign w_ena  = r_ena_s2;
`else
    assign w_step = i_step;
    assign w_dir  = i_dir;
    assign w_ena  = i_ena;
`endif

    // k = energised pole for the half-step index, k1 its neighbour (wraps W-1 -> 0).
    function automatic logic [WIDTH-1:0] f_decode(input logic [CW-1:0] cnt, input logic [1:0] md);
        logic [CW-1:0]    k;
        logic [CW-1:0]    k1;
        logic [WIDTH-1:0] bk;
        logic [WIDTH-1:0] bk1;
        k   = cnt >> 1;
        k1  = (k == CW'(WIDTH-1)) ? '0 : k + CW'(1);
        bk  = {{(WIDTH-1){1'b0}}, 1'b1} << k;
        bk1 = {{(WIDTH-1){1'b0}}, 1'b1} << k1;
        if (md == 2'b00)
            f_decode = bk;
        else if (md == 2'b01)
            f_decode = bk | bk1;
        else
            f_decode = cnt[0] ? (bk | bk1) : bk;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CW-1:0]        r_cnt;
        logic                 r_step_d;
        logic [WIDTH-1:0]     r_phase;
        logic                 r_changed;
        logic [POS_WIDTH-1:0] r_pos;
        logic                 r_fault;
        logic                 w_step_clk;
        logic [1:0]           w_mode;
        logic [CW:0]          w_delta;
        logic [CW:0]          w_sum;
        logic [CW-1:0]        w_cnt_nxt;
        logic [POS_WIDTH-1:0] w_pos_delta;
        logic [WIDTH-1:0]     w_phase_nxt;

        assign w_mode     = i_mode[2*g +: 2];
        assign w_step_clk = w_step[g] & ~r_step_d;

        always_comb begin
            // Wave/full land on even indices, so an odd index left by half mode moves by one.
            w_delta     = (w_mode[1] || r_cnt[0]) ? (CW+1)'(1) : (CW+1)'(2);
            w_sum       = w_dir[g] ? ({1'b0, r_cnt} + TWO_W - w_delta) : ({1'b0, r_cnt} + w_delta);
            if (w_sum >= TWO_W)
                w_sum = w_sum - TWO_W;
            w_cnt_nxt   = w_sum[CW-1:0];
            w_pos_delta = w_dir[g] ? -POS_WIDTH'(w_delta) : POS_WIDTH'(w_delta);
            w_phase_nxt = (i_sclr || !w_ena[g]) ? '0 : f_decode(r_cnt, w_mode);
        end

        always_ff @(posedge clk or posedge aclr) begin
            if (aclr) begin
                r_cnt     <= '0;
                r_step_d  <= 1'b0;
                r_phase   <= '0;
                r_changed <= 1'b0;
                r_pos     <= '0;
                r_fault   <= 1'b0;
            end else begin
                r_step_d  <= w_step[g];
                r_phase   <= w_phase_nxt;
                r_changed <= (w_phase_nxt != r_phase);
                if (i_sclr) begin
                    r_cnt   <= '0;
                    r_pos   <= '0;
                    r_fault <= 1'b0;
                end else if (w_step_clk) begin
                    if (w_ena[g]) begin
                        r_cnt <= w_cnt_nxt;
                        r_pos <= r_pos + w_pos_delta;
                    end else begin
                        r_fault <= 1'b1;
                    end
                end
            end
        end

        assign o_phase[WIDTH*g +: WIDTH]     = r_phase;
        assign o_changed[g]                  = r_changed;
        assign o_pos[POS_WIDTH*g +: POS_WIDTH] = r_pos;
        assign o_fault[g]                    = r_fault;
    end

endmodule

// File: tb/tb_step_dir_mc.sv
// Self-checking bench for step_dir_mc: directed scenarios plus randomized traffic against a position-based model.
module tb_step_dir_mc;
    localparam int CH = 4;
    localparam int W  = 5;
    localparam int PW = 32;
    localparam int TW = 2*W;

    logic              clk = 1'b0;
    logic              aclr;
    logic              sclr;
    logic [CH-1:0]     step;
    logic [CH-1:0]     dir;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     ena;
    logic [CH*W-1:0]   o_phase;
    logic [CH-1:0]     o_changed;
    logic [CH*PW-1:0]  o_pos;
    logic [CH-1:0]     o_fault;

    int checks   = 0;
    int failures = 0;

    // Model: absolute half-step position per channel; coil pattern follows from its electrical angle.
    longint       m_pos   [CH];
    logic         m_prev  [CH];
    logic [W-1:0] m_phase [CH];
    logic         m_chg   [CH];
    logic         m_fault [CH];

    always #5 clk = ~clk;

    step_dir_mc #(.CHANNELS(CH), .WIDTH(W), .POS_WIDTH(PW)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .i_sclr    (sclr),
        .i_step    (step),
        .i_dir     (dir),
        .i_mode    (mode),
        .i_ena     (ena),
        .o_phase   (o_phase),
        .o_changed (o_changed),
        .o_pos     (o_pos),
        .o_fault   (o_fault)
    );

    function automatic logic [W-1:0] coils(input longint p, input logic [1:0] md);
        int           h;
        int           k;
        int           k1;
        logic [W-1:0] a;
        logic [W-1:0] b;
        h  = int'(((p % TW) + TW) % TW);
        k  = h / 2;
        k1 = (k + 1) % W;
        a  = '0;
        b  = '0;
        a[k]  = 1'b1;
        b[k1] = 1'b1;
        case (md)
            2'b00:   return a;
            2'b01:   return a | b;
            default: return (h % 2 == 1) ? (a | b) : a;
        endcase
    endfunction

    function automatic longint advance(input longint p, input logic [1:0] md, input logic rev);
        longint d;
        if (md[1]) d = 1;
        else       d = p[0] ? 1 : 2;
        return rev ? p - d : p + d;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_pos[c]   = 0;
            m_prev[c]  = 1'b0;
            m_phase[c] = '0;
            m_chg[c]   = 1'b0;
            m_fault[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (aclr) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                logic [W-1:0] np;
                logic [1:0]   md;
                md = mode[2*c +: 2];
                np = (sclr || !ena[c]) ? '0 : coils(m_pos[c], md);
                m_chg[c]   = (np != m_phase[c]);
                m_phase[c] = np;
                if (sclr) begin
                    m_pos[c]   = 0;
                    m_fault[c] = 1'b0;
                end else if (step[c] && !m_prev[c]) begin
                    if (ena[c]) m_pos[c]   = advance(m_pos[c], md, dir[c]);
                    else        m_fault[c] = 1'b1;
                end
                m_prev[c] = step[c];
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_aclr();
        aclr = 1'b1;
        sclr = 1'b0;
        step = '0;
        model_reset();
        cyc();
        aclr = 1'b0;
    endtask

    task automatic pulse(input int c);
        step[c] = 1'b1;
        cyc();
        step[c] = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        sclr = 1'b0;
        step = '0;
        dir  = '0;
        ena  = '1;
        mode = 8'b10101010;
        model_reset();
        #1;
        checks++; if (o_phase !== '0)   begin failures++; $display("FAIL rst_phase got=%h exp=0", o_phase); end
        checks++; if (o_pos !== '0)     begin failures++; $display("FAIL rst_pos got=%h exp=0", o_pos); end
        checks++; if (o_changed !== '0) begin failures++; $display("FAIL rst_changed got=%b exp=0", o_changed); end
        checks++; if (o_fault !== '0)   begin failures++; $display("FAIL rst_fault got=%b exp=0", o_fault); end
        cyc();
        aclr = 1'b0;
        cyc();
        checks++; if (o_phase !== {CH{5'b00001}}) begin failures++; $display("FAIL rel_phase got=%h exp=%h", o_phase, {CH{5'b00001}}); end
        checks++; if (o_changed !== '1) begin failures++; $display("FAIL rel_changed got=%b exp=1111", o_changed); end
        cyc();
        checks++; if (o_changed !== '0) begin failures++; $display("FAIL rel_changed2 got=%b exp=0000", o_changed); end
    endtask

    task automatic test_half_seq();
        logic [W-1:0] exp_tab [10];
        int pulses;
        exp_tab = '{5'b00011, 5'b00010, 5'b00110, 5'b00100, 5'b01100,
                    5'b01000, 5'b11000, 5'b10000, 5'b10001, 5'b00001};
        do_aclr();
        mode = 8'b10101010;
        dir  = '0;
        ena  = '1;
        cyc();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step[0] = 1'b1;
            cyc();
            pulses += int'(o_changed[0]);
            step[0] = 1'b0;
            cyc();
            pulses += int'(o_changed[0]);
            checks++;
            if (o_phase[W-1:0] !== exp_tab[i]) begin
                failures++; $display("FAIL half_seq step%0d got=%b exp=%b", i, o_phase[W-1:0], exp_tab[i]);
            end
            cyc();
            pulses += int'(o_changed[0]);
        end
        checks++; if (o_pos[PW-1:0] !== 32'd10) begin failures++; $display("FAIL half_pos got=%h exp=10", o_pos[PW-1:0]); end
        checks++; if (pulses != 10) begin failures++; $display("FAIL half_pulses got=%0d exp=10", pulses); end
    endtask

    task automatic test_full_rev();
        do_aclr();
        mode = 8'b10101001;
        dir  = 4'b0001;
        ena  = '1;
        cyc();
        pulse(0);
        checks++; if (o_phase[W-1:0] !== 5'b10001) begin failures++; $display("FAIL full_rev_phase got=%b exp=10001", o_phase[W-1:0]); end
        checks++; if (o_pos[PW-1:0] !== 32'hFFFFFFFE) begin failures++; $display("FAIL full_rev_pos got=%h exp=fffffffe", o_pos[PW-1:0]); end
    endtask

    task automatic test_realign();
        for (int r = 0; r < 2; r++) begin
            logic [W-1:0] ep;
            logic [PW-1:0] epos;
            ep   = (r == 1) ? 5'b00010 : 5'b00100;
            epos = (r == 1) ? 32'd2 : 32'd4;
            do_aclr();
            mode = 8'b10101010;
            dir  = '0;
            ena  = '1;
            cyc();
            pulse(0); pulse(0); pulse(0);
            checks++; if (o_pos[PW-1:0] !== 32'd3) begin failures++; $display("FAIL realign_pre%0d got=%h exp=3", r, o_pos[PW-1:0]); end
            mode[1:0] = 2'b00;
            dir[0]    = (r == 1);
            pulse(0);
            checks++; if (o_phase[W-1:0] !== ep) begin failures++; $display("FAIL realign_phase%0d got=%b exp=%b", r, o_phase[W-1:0], ep); end
            checks++; if (o_pos[PW-1:0] !== epos) begin failures++; $display("FAIL realign_pos%0d got=%h exp=%h", r, o_pos[PW-1:0], epos); end
        end
    endtask

    task automatic test_enable();
        do_aclr();
        mode = 8'b10101010;
        dir  = '0;
        ena  = '1;
        cyc();
        pulse(0); pulse(0);
        ena[0] = 1'b0;
        cyc();
        checks++; if (o_phase[W-1:0] !== 5'b00000) begin failures++; $display("FAIL dis_phase got=%b exp=00000", o_phase[W-1:0]); end
        checks++; if (o_changed[0] !== 1'b1) begin failures++; $display("FAIL dis_changed got=%b exp=1", o_changed[0]); end
        pulse(0); pulse(0); pulse(0);
        checks++; if (o_pos[PW-1:0] !== 32'd2) begin failures++; $display("FAIL dis_pos got=%h exp=2", o_pos[PW-1:0]); end
        checks++; if (o_fault[0] !== 1'b1) begin failures++; $display("FAIL dis_fault got=%b exp=1", o_fault[0]); end
        ena[0] = 1'b1;
        cyc();
        checks++; if (o_phase[W-1:0] !== 5'b00010) begin failures++; $display("FAIL en_phase got=%b exp=00010", o_phase[W-1:0]); end
        checks++; if (o_changed[0] !== 1'b1) begin failures++; $display("FAIL en_changed got=%b exp=1", o_changed[0]); end
        sclr = 1'b1;
        cyc();
        checks++; if (o_fault[0] !== 1'b0) begin failures++; $display("FAIL sclr_fault got=%b exp=0", o_fault[0]); end
        checks++; if (o_pos[PW-1:0] !== '0) begin failures++; $display("FAIL sclr_pos got=%h exp=0", o_pos[PW-1:0]); end
        sclr = 1'b0;
        cyc();
        checks++; if (o_phase[W-1:0] !== 5'b00001) begin failures++; $display("FAIL sclr_rel got=%b exp=00001", o_phase[W-1:0]); end
    endtask

    task automatic test_step_held();
        do_aclr();
        mode = 8'b10101010;
        dir  = '0;
        ena  = '1;
        cyc();
        step[1] = 1'b1;
        cycles(20);
        step[1] = 1'b0;
        cyc();
        checks++; if (o_pos[PW +: PW] !== 32'd1) begin failures++; $display("FAIL held_pos got=%h exp=1", o_pos[PW +: PW]); end
        for (int i = 0; i < 20; i++) begin
            step[1] = ~step[1];
            cyc();
        end
        step[1] = 1'b0;
        cyc();
        checks++; if (o_pos[PW +: PW] !== 32'd11) begin failures++; $display("FAIL toggle_pos got=%h exp=11", o_pos[PW +: PW]); end
    endtask

    task automatic test_all_channels();
        do_aclr();
        mode = {2'b11, 2'b10, 2'b01, 2'b00};
        dir  = 4'($urandom);
        ena  = '1;
        cyc();
        for (int i = 0; i < 16; i++) begin
            step = (i % 2 == 0) ? '1 : '0;
            cyc();
            for (int c = 0; c < CH; c++) begin
                checks++; if (o_phase[W*c +: W] !== m_phase[c]) begin failures++; $display("FAIL all_phase ch%0d got=%b exp=%b", c, o_phase[W*c +: W], m_phase[c]); end
                checks++; if (o_pos[PW*c +: PW] !== PW'(m_pos[c])) begin failures++; $display("FAIL all_pos ch%0d got=%h exp=%h", c, o_pos[PW*c +: PW], PW'(m_pos[c])); end
                checks++; if (o_changed[c] !== m_chg[c]) begin failures++; $display("FAIL all_changed ch%0d got=%b exp=%b", c, o_changed[c], m_chg[c]); end
            end
        end
        step = '1;
        aclr = 1'b1;
        model_reset();
        #1;
        checks++; if ({o_phase, o_pos, o_changed, o_fault} !== '0) begin failures++; $display("FAIL mid_aclr got=%h/%h exp=0", o_phase, o_pos); end
        @(negedge clk);
        aclr = 1'b0;
        step = '0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            step = '1; cyc();
            step = '0; cyc();
        end
        sclr = 1'b1;
        cycles(2);
        sclr = 1'b0;
        cyc();
        checks++; if (o_phase[W-1:0] !== 5'b00001) begin failures++; $display("FAIL mid_sclr_phase got=%b exp=00001", o_phase[W-1:0]); end
        for (int c = 0; c < CH; c++) begin
            checks++; if (o_pos[PW*c +: PW] !== '0) begin failures++; $display("FAIL mid_sclr_pos ch%0d got=%h exp=0", c, o_pos[PW*c +: PW]); end
            checks++; if (o_phase[W*c +: W] !== m_phase[c]) begin failures++; $display("FAIL mid_sclr_ph ch%0d got=%b exp=%b", c, o_phase[W*c +: W], m_phase[c]); end
        end
    endtask

    task automatic test_random();
        do_aclr();
        for (int i = 0; i < 1500; i++) begin
            step = 4'($urandom);
            dir  = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            ena  = 4'($urandom) | 4'($urandom) | 4'($urandom);
            sclr = ($urandom_range(0, 49) == 0);
            cyc();
            for (int c = 0; c < CH; c++) begin
                checks++; if (o_phase[W*c +: W] !== m_phase[c]) begin failures++; $display("FAIL rnd_phase cyc%0d ch%0d got=%b exp=%b", i, c, o_phase[W*c +: W], m_phase[c]); end
                checks++; if (o_pos[PW*c +: PW] !== PW'(m_pos[c])) begin failures++; $display("FAIL rnd_pos cyc%0d ch%0d got=%h exp=%h", i, c, o_pos[PW*c +: PW], PW'(m_pos[c])); end
                checks++; if (o_changed[c] !== m_chg[c]) begin failures++; $display("FAIL rnd_changed cyc%0d ch%0d got=%b exp=%b", i, c, o_changed[c], m_chg[c]); end
                checks++; if (o_fault[c] !== m_fault[c]) begin failures++; $display("FAIL rnd_fault cyc%0d ch%0d got=%b exp=%b", i, c, o_fault[c], m_fault[c]); end
            end
        end
        sclr = 1'b0;
        step = '0;
    endtask

    initial begin
        test_reset();
        test_half_seq();
        test_full_rev();
        test_realign();
        test_enable();
        test_step_held();
        test_all_channels();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
